// File: rtl/processor_ctrl_pkg.sv
// Shared state encoding and parameter-range checks for the processor run controller.
package processor_ctrl_pkg;

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] TIMEOUT = 2'd3;

  localparam int MIN_RESET_CYCLES = 1;
  localparam int MIN_MAX_CYCLES   = 1;
  localparam int MIN_NUM_FLAGS    = 1;
  localparam int MAX_CNT_W        = 63;

  function automatic bit params_ok(input int reset_cycles, input int max_cycles,
                                   input int num_flags, input int cnt_w);
    longint cnt_max;
    if (cnt_w < 1 || cnt_w > MAX_CNT_W) return 1'b0;
    cnt_max = (longint'(1) << cnt_w) - 1;
    return (reset_cycles >= MIN_RESET_CYCLES) && (max_cycles >= MIN_MAX_CYCLES) &&
           (longint'(max_cycles) <= cnt_max) && (num_flags >= MIN_NUM_FLAGS);
  endfunction

endpackage

// File: rtl/run_flag_counter.sv
// Saturating per-flag activity counter, advancing only on RUN edges (level or rising-edge mode).
// Count is registered (visible one cycle after the sampled edge); no backpressure.
module run_flag_counter #(
  parameter int CNT_W     = 16,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic             flag,
  output logic [CNT_W-1:0] count
);

  logic prev_flag;
  logic hit;

  // prev_flag starts at 0 on every run, so a flag already high on entry counts as one edge.
  always_comb begin
    hit = (EDGE_MODE != 0) ? (flag && !prev_flag) : flag;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count     <= '0;
      prev_flag <= 1'b0;
    end else if (run) begin
      prev_flag <= flag;
      if (hit && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/processor_run_controller.sv
// Core run controller: holds core reset, runs a bounded number of cycles, stops on halt/timeout.
// Moore outputs from registered state; no backpressure (restart honoured only in DONE/TIMEOUT).
module processor_run_controller
  import processor_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 8,
  parameter int NUM_FLAGS    = 1,
  parameter int CNT_W        = 16,
  parameter int EDGE_MODE    = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic                       halt,
  input  logic [NUM_FLAGS-1:0]       flags,
  output logic                       core_reset,
  output logic                       running,
  output logic                       done,
  output logic                       timeout,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [NUM_FLAGS*CNT_W-1:0] flag_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  if (!params_ok(RESET_CYCLES, MAX_CYCLES, NUM_FLAGS, CNT_W)) begin : g_param_err
    $error("processor_run_controller: parameter out of range");
  end

  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              in_run;
  logic              clear_all;

  always_comb begin
    in_run    = (state == RUN);
    clear_all = reset || (((state == DONE) || (state == TIMEOUT)) && restart);
  end

  always_ff @(posedge clk) begin
    if (clear_all) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
            state <= RUN;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          // The exiting edge is still a RUN cycle, so it is counted too; halt beats timeout.
          cycle_count <= cycle_count + CNT_W'(1);
          if (halt) begin
            state <= DONE;
          end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
            state <= TIMEOUT;
          end
        end
        DONE, TIMEOUT: begin
        end
        default: begin
          state       <= HOLD;
          hold_cnt    <= '0;
          cycle_count <= '0;
        end
      endcase
    end
  end

  assign core_reset = (state == HOLD);
  assign running    = (state == RUN);
  assign done       = (state == DONE);
  assign timeout    = (state == TIMEOUT);

  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
    run_flag_counter #(
      .CNT_W    (CNT_W),
      .EDGE_MODE(EDGE_MODE)
    ) u_flag_counter (
      .clk  (clk),
      .clear(clear_all),
      .run  (in_run),
      .flag (flags[i]),
      .count(flag_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_processor_run_controller.sv
// Directed bench: vector table for the default/two-flag controller, hand sequence for edge mode and saturation.
module tb_processor_run_controller;

  localparam logic [1:0] SH = 2'd0;
  localparam logic [1:0] SR = 2'd1;
  localparam logic [1:0] SD = 2'd2;
  localparam logic [1:0] ST = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  flags_a = '0;
  logic        flags_b = 1'b0;
  logic        flags_c = 1'b0;

  logic        core_reset_a, running_a, done_a, timeout_a;
  logic [15:0] cycle_count_a;
  logic [31:0] flag_count_a;
  logic        core_reset_b, running_b, done_b, timeout_b;
  logic [15:0] cycle_count_b;
  logic [15:0] flag_count_b;
  logic        core_reset_c, running_c, done_c, timeout_c;
  logic [2:0]  cycle_count_c;
  logic [2:0]  flag_count_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  processor_run_controller #(
    .RESET_CYCLES(2), .MAX_CYCLES(8), .NUM_FLAGS(2), .CNT_W(16), .EDGE_MODE(0)
  ) dut_a (
    .clk(clk), .reset(reset), .restart(restart), .halt(halt), .flags(flags_a),
    .core_reset(core_reset_a), .running(running_a), .done(done_a), .timeout(timeout_a),
    .cycle_count(cycle_count_a), .flag_count(flag_count_a)
  );

  processor_run_controller #(
    .RESET_CYCLES(2), .MAX_CYCLES(8), .NUM_FLAGS(1), .CNT_W(16), .EDGE_MODE(1)
  ) dut_b (
    .clk(clk), .reset(reset), .restart(restart), .halt(halt), .flags(flags_b),
    .core_reset(core_reset_b), .running(running_b), .done(done_b), .timeout(timeout_b),
    .cycle_count(cycle_count_b), .flag_count(flag_count_b)
  );

  processor_run_controller #(
    .RESET_CYCLES(2), .MAX_CYCLES(7), .NUM_FLAGS(1), .CNT_W(3), .EDGE_MODE(0)
  ) dut_c (
    .clk(clk), .reset(reset), .restart(restart), .halt(halt), .flags(flags_c),
    .core_reset(core_reset_c), .running(running_c), .done(done_c), .timeout(timeout_c),
    .cycle_count(cycle_count_c), .flag_count(flag_count_c)
  );

  typedef struct {
    logic       rst;
    logic       rs;
    logic       hlt;
    logic [1:0] fl;
    logic [1:0] st;
    int         cc;
    int         f0;
    int         f1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rs, input logic hlt, input logic [1:0] fl,
                     input logic [1:0] st, input int cc, input int f0, input int f1);
    vec_t v;
    v.rst = rst; v.rs = rs; v.hlt = hlt; v.fl = fl;
    v.st = st; v.cc = cc; v.f0 = f0; v.f1 = f1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_oh;
    logic       pat [8];
    logic       prev_b;
    int         cnt_b;
    int         exp_c;

    // First run: reset, two hold cycles, 8 RUN cycles, timeout; halt/flags ignored after.
    add(1,0,0,2'b00, SH,0,0,0);
    add(1,0,0,2'b00, SH,0,0,0);
    add(0,0,0,2'b00, SH,0,0,0);
    add(0,0,0,2'b00, SR,0,0,0);
    add(0,0,0,2'b11, SR,1,1,1);
    add(0,0,0,2'b01, SR,2,2,1);
    add(0,0,0,2'b11, SR,3,3,2);
    add(0,0,0,2'b00, SR,4,3,2);
    add(0,0,0,2'b10, SR,5,3,3);
    add(0,0,0,2'b00, SR,6,3,3);
    add(0,0,0,2'b10, SR,7,3,4);
    add(0,0,0,2'b00, ST,8,3,4);
    add(0,0,1,2'b11, ST,8,3,4);
    // Restart from TIMEOUT; restart held into HOLD and pulsed during RUN must be ignored.
    add(0,1,0,2'b00, SH,0,0,0);
    add(0,1,0,2'b00, SH,0,0,0);
    add(0,0,0,2'b00, SR,0,0,0);
    add(0,1,0,2'b11, SR,1,1,1);
    add(0,0,0,2'b01, SR,2,2,1);
    add(0,1,0,2'b11, SR,3,3,2);
    add(0,0,0,2'b00, SR,4,3,2);
    add(0,0,0,2'b10, SR,5,3,3);
    add(0,0,0,2'b00, SR,6,3,3);
    add(0,1,0,2'b10, SR,7,3,4);
    add(0,0,0,2'b00, ST,8,3,4);
    // Halt in the 4th RUN cycle; flags still count on the exiting edge.
    add(0,1,0,2'b00, SH,0,0,0);
    add(0,0,0,2'b00, SH,0,0,0);
    add(0,0,0,2'b00, SR,0,0,0);
    add(0,0,0,2'b01, SR,1,1,0);
    add(0,0,0,2'b00, SR,2,1,0);
    add(0,0,0,2'b00, SR,3,1,0);
    add(0,0,1,2'b10, SD,4,1,1);
    add(0,0,1,2'b11, SD,4,1,1);
    add(0,0,0,2'b00, SD,4,1,1);
    // Halt on the same edge as the timeout: DONE wins.
    add(0,1,0,2'b00, SH,0,0,0);
    add(0,0,0,2'b00, SH,0,0,0);
    add(0,0,0,2'b00, SR,0,0,0);
    for (int k = 1; k <= 7; k++) add(0,0,0,2'b00, SR,k,0,0);
    add(0,0,1,2'b00, SD,8,0,0);
    add(0,0,0,2'b00, SD,8,0,0);
    // Reset mid-RUN clears everything on the next edge.
    add(0,1,0,2'b00, SH,0,0,0);
    add(0,0,0,2'b00, SH,0,0,0);
    add(0,0,0,2'b00, SR,0,0,0);
    add(0,0,0,2'b11, SR,1,1,1);
    add(0,0,0,2'b11, SR,2,2,2);
    add(1,0,0,2'b11, SH,0,0,0);
    add(0,0,0,2'b11, SH,0,0,0);
    add(0,0,0,2'b00, SR,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      restart = vecs[i].rs;
      halt    = vecs[i].hlt;
      flags_a = vecs[i].fl;
      @(posedge clk);
      #1;
      exp_oh = 4'b0001 << vecs[i].st;
      check($sformatf("v%0d_state", i), {28'd0, timeout_a, done_a, running_a, core_reset_a},
            {28'd0, exp_oh});
      check($sformatf("v%0d_cycle_count", i), {16'd0, cycle_count_a}, vecs[i].cc);
      check($sformatf("v%0d_flag0", i), {16'd0, flag_count_a[15:0]}, vecs[i].f0);
      check($sformatf("v%0d_flag1", i), {16'd0, flag_count_a[31:16]}, vecs[i].f1);
    end

    // Edge-mode and small-counter instances: fresh reset, then 8 RUN edges.
    reset = 1'b1; restart = 1'b0; halt = 1'b0; flags_a = '0; flags_b = 1'b0; flags_c = 1'b0;
    @(posedge clk); #1;
    check("bc_reset_core_reset", {30'd0, core_reset_b, core_reset_c}, 32'd3);
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bc_enter_run", {30'd0, running_b, running_c}, 32'd3);

    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    prev_b = 1'b0;
    cnt_b  = 0;
    for (int k = 1; k <= 8; k++) begin
      flags_b = pat[k-1];
      flags_c = 1'b1;
      @(posedge clk); #1;
      if (pat[k-1] && !prev_b) cnt_b++;
      prev_b = pat[k-1];
      exp_c  = (k < 7) ? k : 7;
      check($sformatf("b%0d_edge_count", k), {16'd0, flag_count_b}, cnt_b);
      check($sformatf("b%0d_timeout", k), {31'd0, timeout_b}, (k == 8) ? 32'd1 : 32'd0);
      check($sformatf("c%0d_flag_count", k), {29'd0, flag_count_c}, exp_c);
      check($sformatf("c%0d_cycle_count", k), {29'd0, cycle_count_c}, exp_c);
      check($sformatf("c%0d_timeout", k), {31'd0, timeout_c}, (k >= 7) ? 32'd1 : 32'd0);
    end
    check("b_final_edge_count", {16'd0, flag_count_b}, 32'd2);
    check("b_final_cycle_count", {16'd0, cycle_count_b}, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
